mult16_seq_ctrl: RTL

- Sequencing controller that computes a 16x16 unsigned product by time-multiplexing one instance of the team's 8x8 Wallace core over four passes, accumulating shifted partial products.
- It trades the four-core area of the parallel 16-bit multiplier for a multi-cycle latency.
- It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult16_seq_ctrl_wallace_8.sv | 53 +++++
 rtl/mult16_seq_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier.
// Holds the controller state enum, pass shift table and widths.
package mult_pkg;

  localparam int OP_W   = 16;
  localparam int CORE_W = 8;
  localparam int P_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DRAIN,
    DONE
  } state_t;

  localparam logic [4:0] PASS_SHIFT [4] = '{5'd0, 5'd8, 5'd8, 5'd16};

endpackage

// File: rtl/mult16_seq_ctrl_wallace_8.sv
// 8x8 unsigned Wallace-tree multiplier core, purely combinational.
// Ports: a, b (8-bit operands), p (16-bit product).
module wallace_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [15:0] sum3(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] car3(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] pp [8];
  logic [15:0] s1a, c1a, s1b, c1b;
  logic [15:0] s2a, c2a, s2b, c2b;
  logic [15:0] s3, c3, s4, c4;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = {8'b0, a & {8{b[i]}}} << i;
    end
  end

  // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add
  always_comb begin
    s1a = sum3(pp[0], pp[1], pp[2]);
    c1a = car3(pp[0], pp[1], pp[2]);
    s1b = sum3(pp[3], pp[4], pp[5]);
    c1b = car3(pp[3], pp[4], pp[5]);
    s2a = sum3(s1a, c1a, s1b);
    c2a = car3(s1a, c1a, s1b);
    s2b = sum3(c1b, pp[6], pp[7]);
    c2b = car3(c1b, pp[6], pp[7]);
    s3  = sum3(s2a, c2a, s2b);
    c3  = car3(s2a, c2a, s2b);
    s4  = sum3(s3, c3, c2b);
    c4  = car3(s3, c3, c2b);
    p   = s4 + c4;
  end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// 16x16 multiplier sequencing one 8x8 core over four passes.
// Ports: in_* operand handshake, out_* product handshake, busy, op_cnt.
module mult16_seq_ctrl
  import mult_pkg::*;
#(
  parameter int ACC_PIPE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_p,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  state_t              state;
  logic [1:0]          pass;
  logic [OP_W-1:0]     a_r;
  logic [OP_W-1:0]     b_r;
  logic [P_W-1:0]      acc;
  logic [CORE_W-1:0]   core_a;
  logic [CORE_W-1:0]   core_b;
  logic [2*CORE_W-1:0] core_p;
  logic [2*CORE_W-1:0] prod_r;
  logic [4:0]          shift_r;
  logic                prod_v;
  logic [P_W-1:0]      term;
  logic [P_W-1:0]      acc_nxt;

  // pass[0] picks the high multiplicand byte, pass[1] the high multiplier byte
  always_comb begin
    core_a = pass[0] ? a_r[15:8] : a_r[7:0];
    core_b = pass[1] ? b_r[15:8] : b_r[7:0];
  end

  wallace_8 u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  always_comb begin
    if (ACC_PIPE != 0) begin
      term = prod_v ? ({16'b0, prod_r} << shift_r) : '0;
    end else begin
      term = {16'b0, core_p} << PASS_SHIFT[pass];
    end
    acc_nxt = acc + term;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pass      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      prod_r    <= '0;
      shift_r   <= '0;
      prod_v    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      busy      <= 1'b0;
      op_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            acc      <= '0;
            pass     <= '0;
            prod_v   <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MUL: begin
          acc  <= acc_nxt;
          pass <= pass + 2'd1;
          if (ACC_PIPE != 0) begin
            prod_r  <= core_p;
            shift_r <= PASS_SHIFT[pass];
            prod_v  <= 1'b1;
          end
          if (pass == 2'd3) begin
            if (ACC_PIPE != 0) begin
              state <= DRAIN;
            end else begin
              out_p     <= acc_nxt;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DRAIN: begin
          acc       <= acc_nxt;
          out_p     <= acc_nxt;
          out_valid <= 1'b1;
          prod_v    <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_cnt    <= op_cnt + 1'b1;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
